mac_feeder: RTL and testbench

Operand sequencer driving the `cmac` convolution MAC from the other side of its interface. It reads data and weight words from two on-chip buffers, presents each operand pair to the MAC in step with the MAC's accumulate-done pulses, presents the bias for the final stage, and captures the MAC result. It sits between the layer scheduler (job command) and one `cmac` instance.

---
 rtl/mac_feeder_if.sv | 49 ++++
 rtl/mac_feeder.sv | 205 ++++++++++++++++++++
 tb/tb_mac_feeder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_feeder_if.sv
// Job command, operand buffer read ports and cmac operand/result bundle for mac_feeder.
// master = the feeder, slave = scheduler/buffers/MAC side.
interface mac_feeder_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] data_base;
  logic [ADDR_W-1:0] weight_base;
  logic [15:0]       bias;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       result;

  logic              dbuf_rd;
  logic              wbuf_rd;
  logic [ADDR_W-1:0] dbuf_addr;
  logic [ADDR_W-1:0] wbuf_addr;
  logic [15:0]       dbuf_q;
  logic [15:0]       wbuf_q;

  logic              mac_rst;
  logic              conv_ready;
  logic [31:0]       op_num;
  logic [15:0]       mac_data;
  logic [15:0]       mac_weight;
  logic              rdy_acc;
  logic              conv_valid;
  logic [15:0]       mac_result;

  modport master (
    input  start, len, data_base, weight_base, bias,
    output busy, done, err, result,
    output dbuf_rd, wbuf_rd, dbuf_addr, wbuf_addr,
    input  dbuf_q, wbuf_q,
    output mac_rst, conv_ready, op_num, mac_data, mac_weight,
    input  rdy_acc, conv_valid, mac_result
  );

  modport slave (
    output start, len, data_base, weight_base, bias,
    input  busy, done, err, result,
    input  dbuf_rd, wbuf_rd, dbuf_addr, wbuf_addr,
    output dbuf_q, wbuf_q,
    input  mac_rst, conv_ready, op_num, mac_data, mac_weight,
    output rdy_acc, conv_valid, mac_result
  );
endinterface

// File: rtl/mac_feeder.sv
// Operand sequencer for cmac: fetches data/weight pairs from two buffers, advances one pair per
// rdy_acc pulse through a one-deep prefetch, finishes with the bias stage and captures the result.
module mac_feeder #(
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         rst,
  mac_feeder_if.master io_bus
);

  localparam int CW = ADDR_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_PRIME,
    S_RUN,
    S_BIAS
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [ADDR_W:0]   r_len;
  logic [ADDR_W-1:0] r_dbase;
  logic [ADDR_W-1:0] r_wbase;
  logic [15:0]       r_bias;
  logic [31:0]       r_op_num;
  logic [CW-1:0]     r_taken;

  logic [15:0]       r_pf_d;
  logic [15:0]       r_pf_w;
  logic              r_pf_vld;
  logic              r_pend;

  logic [15:0]       r_mac_d;
  logic [15:0]       r_mac_w;
  logic [15:0]       r_result;
  logic              r_done;
  logic              r_err;
  logic              r_acc_viol;

  logic [CW-1:0]     w_len_x;
  logic [CW-1:0]     w_tk1;
  logic [CW-1:0]     w_tk2;
  logic              w_accept;
  logic              w_have_op;
  logic              w_last;
  logic              w_adv;
  logic              w_fin;
  logic              w_viol;
  logic [15:0]       w_op_d;
  logic [15:0]       w_op_w;

  logic              w_rd;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_mac_rst;
  logic              w_conv_ready;

  assign w_len_x  = {1'b0, r_len};
  assign w_tk1    = r_taken + CW'(1);
  assign w_tk2    = r_taken + CW'(2);
  assign w_accept = io_bus.start && (io_bus.len != '0);

  // A pair can be handed over from the prefetch register or straight off the buffer port
  // when its read returns in the same cycle the MAC asks for it.
  assign w_have_op = r_pf_vld || r_pend;
  assign w_op_d    = r_pf_vld ? r_pf_d : io_bus.dbuf_q;
  assign w_op_w    = r_pf_vld ? r_pf_w : io_bus.wbuf_q;

  assign w_last = (w_tk1 == w_len_x);
  assign w_adv  = (r_state == S_RUN) && io_bus.rdy_acc && !w_last && w_have_op;
  assign w_fin  = (r_state == S_RUN) && io_bus.rdy_acc && w_last;
  assign w_viol = (r_state == S_RUN) && io_bus.rdy_acc && !w_last && !w_have_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_rd         = 1'b0;
    w_rd_idx     = '0;
    w_mac_rst    = 1'b0;
    w_conv_ready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_CLR;
      end
      S_CLR: begin
        w_mac_rst = 1'b1;
        w_rd      = 1'b1;
        w_next    = S_PRIME;
      end
      S_PRIME: begin
        w_rd     = (r_len > (ADDR_W+1)'(1));
        w_rd_idx = ADDR_W'(1);
        w_next   = S_RUN;
      end
      S_RUN: begin
        w_conv_ready = 1'b1;
        if (w_adv && (w_tk2 < w_len_x)) begin
          w_rd     = 1'b1;
          w_rd_idx = w_tk2[ADDR_W-1:0];
        end
        if (w_fin) w_next = S_BIAS;
      end
      S_BIAS: begin
        if (io_bus.conv_valid) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len      <= '0;
      r_dbase    <= '0;
      r_wbase    <= '0;
      r_bias     <= '0;
      r_op_num   <= '0;
      r_taken    <= '0;
      r_pf_d     <= '0;
      r_pf_w     <= '0;
      r_pf_vld   <= 1'b0;
      r_pend     <= 1'b0;
      r_mac_d    <= '0;
      r_mac_w    <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_acc_viol <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      // Index 0 read in CLR goes straight to the MAC in PRIME, so it never enters the prefetch.
      r_pend <= w_rd && (r_state != S_CLR);
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_len    <= io_bus.len;
            r_dbase  <= io_bus.data_base;
            r_wbase  <= io_bus.weight_base;
            r_bias   <= io_bus.bias;
            r_op_num <= 32'(io_bus.len) - 32'd1;
            r_taken  <= '0;
            r_pf_vld <= 1'b0;
          end else if (io_bus.start) begin
            r_err <= 1'b1;
          end
        end
        S_PRIME: begin
          r_mac_d <= io_bus.dbuf_q;
          r_mac_w <= io_bus.wbuf_q;
        end
        S_RUN: begin
          if (w_adv) begin
            r_mac_d  <= w_op_d;
            r_mac_w  <= w_op_w;
            r_pf_vld <= 1'b0;
            r_taken  <= w_tk1;
          end else if (r_pend) begin
            r_pf_d   <= io_bus.dbuf_q;
            r_pf_w   <= io_bus.wbuf_q;
            r_pf_vld <= 1'b1;
          end
          if (w_fin) begin
            r_mac_d <= '0;
            r_mac_w <= r_bias;
          end
          if (w_viol) r_acc_viol <= 1'b1;
        end
        S_BIAS: begin
          if (io_bus.conv_valid) begin
            r_result <= io_bus.mac_result;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // MAC pacing contract: a request must never find the prefetch empty.
  a_no_acc_viol: assert property (@(posedge clk) disable iff (rst) !r_acc_viol);

  assign io_bus.busy       = (r_state != S_IDLE);
  assign io_bus.done       = r_done;
  assign io_bus.err        = r_err;
  assign io_bus.result     = r_result;
  assign io_bus.dbuf_rd    = w_rd;
  assign io_bus.wbuf_rd    = w_rd;
  assign io_bus.dbuf_addr  = w_rd ? (r_dbase + w_rd_idx) : '0;
  assign io_bus.wbuf_addr  = w_rd ? (r_wbase + w_rd_idx) : '0;
  assign io_bus.mac_rst    = w_mac_rst;
  assign io_bus.conv_ready = w_conv_ready;
  assign io_bus.op_num     = r_op_num;
  assign io_bus.mac_data   = r_mac_d;
  assign io_bus.mac_weight = r_mac_w;

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: buffer and MAC models around the DUT, results and pair order checked
// against sums computed directly from the buffer contents.
module tb_mac_feeder;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_feeder_if #(.ADDR_W(AW)) bus();
  mac_feeder #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .io_bus(bus));

  int n_chk = 0;
  int n_bad = 0;

  logic [15:0] dmem [DEPTH];
  logic [15:0] wmem [DEPTH];
  logic [15:0] vals [8] = '{16'h0000, 16'h3400, 16'h3800, 16'h3C00,
                            16'h4000, 16'h4200, 16'hBC00, 16'hC000};
  int d_addr_q[$];
  int w_addr_q[$];
  logic d_pend = 1'b0;
  logic w_pend = 1'b0;
  logic [AW-1:0] d_a = '0;
  logic [AW-1:0] w_a = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    m = (h[14:10] == 5'd0) ? real'(h[9:0]) : real'(1024 + int'(h[9:0]));
    e = (h[14:10] == 5'd0) ? -24 : int'(h[14:10]) - 25;
    if (e > 0) repeat (e) m = m * 2.0;
    else repeat (-e) m = m / 2.0;
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real a;
    int e;
    logic [15:0] h;
    if (r == 0.0) return 16'h0000;
    a = (r < 0.0) ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    h[15]    = (r < 0.0);
    h[14:10] = 5'(e + 15);
    h[9:0]   = 10'($rtoi((a - 1.0) * 1024.0 + 0.5));
    return h;
  endfunction

  // Buffer model: strobe seen mid-cycle, data presented just after the next edge.
  always @(negedge clk) begin
    d_pend = bus.dbuf_rd;
    w_pend = bus.wbuf_rd;
    d_a    = bus.dbuf_addr;
    w_a    = bus.wbuf_addr;
    if (bus.dbuf_rd) d_addr_q.push_back(int'(bus.dbuf_addr));
    if (bus.wbuf_rd) w_addr_q.push_back(int'(bus.wbuf_addr));
  end

  always @(posedge clk) begin
    #1;
    bus.dbuf_q = d_pend ? dmem[d_a] : 16'($urandom);
    bus.wbuf_q = w_pend ? wmem[w_a] : 16'($urandom);
  end

  task automatic check_reset_vals(input string pre);
    chk({pre, "_busy"}, 32'(bus.busy), 0);
    chk({pre, "_done"}, 32'(bus.done), 0);
    chk({pre, "_err"}, 32'(bus.err), 0);
    chk({pre, "_result"}, 32'(bus.result), 0);
    chk({pre, "_rd"}, 32'({bus.dbuf_rd, bus.wbuf_rd}), 0);
    chk({pre, "_addr"}, 32'({bus.dbuf_addr, bus.wbuf_addr}), 0);
    chk({pre, "_macrst"}, 32'(bus.mac_rst), 0);
    chk({pre, "_convrdy"}, 32'(bus.conv_ready), 0);
    chk({pre, "_opnum"}, bus.op_num, 0);
    chk({pre, "_macd"}, 32'(bus.mac_data), 0);
    chk({pre, "_macw"}, 32'(bus.mac_weight), 0);
  endtask

  // Issues a job and plays the MAC; called at #1 after an edge with the DUT idle.
  task automatic run_job(input int n, input int db, input int wb, input logic [15:0] b,
                         output logic [15:0] res_seen);
    real acc;
    real ref_sum;
    logic [15:0] exp_res;
    int nd;
    int nw;
    ref_sum = h2r(b);
    for (int i = 0; i < n; i++)
      ref_sum = ref_sum + h2r(dmem[(db + i) % DEPTH]) * h2r(wmem[(wb + i) % DEPTH]);
    if (ref_sum < 0.0) ref_sum = 0.0;
    exp_res = r2h(ref_sum);
    d_addr_q.delete();
    w_addr_q.delete();

    bus.start = 1'b1; bus.len = 11'(n); bus.data_base = 10'(db);
    bus.weight_base = 10'(wb); bus.bias = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.len = 11'($urandom); bus.data_base = 10'($urandom);
    bus.weight_base = 10'($urandom); bus.bias = 16'($urandom);
    chk("clr_mac_rst", 32'(bus.mac_rst), 1);
    chk("clr_busy", 32'(bus.busy), 1);
    chk("clr_conv_ready", 32'(bus.conv_ready), 0);
    bus.conv_valid = 1'b0;
    @(posedge clk); #1;
    chk("prime_mac_rst", 32'(bus.mac_rst), 0);
    chk("prime_conv_ready", 32'(bus.conv_ready), 0);
    @(posedge clk); #1;
    chk("run_conv_ready", 32'(bus.conv_ready), 1);
    chk("run_op_num", bus.op_num, 32'(n - 1));
    bus.start = 1'b1; bus.len = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_start_err", 32'(bus.err), 0);
    chk("busy_start_busy", 32'(bus.busy), 1);

    acc = 0.0;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(2, 5)) begin @(posedge clk); #1; end
      chk("pair_d", 32'(bus.mac_data), 32'(dmem[(db + k) % DEPTH]));
      chk("pair_w", 32'(bus.mac_weight), 32'(wmem[(wb + k) % DEPTH]));
      acc = acc + h2r(bus.mac_data) * h2r(bus.mac_weight);
      bus.rdy_acc = 1'b1;
      @(posedge clk); #1;
      bus.rdy_acc = 1'b0;
    end

    chk("bias_d", 32'(bus.mac_data), 0);
    chk("bias_w", 32'(bus.mac_weight), 32'(b));
    chk("bias_conv_ready", 32'(bus.conv_ready), 0);
    bus.rdy_acc = 1'b1;
    @(posedge clk); #1;
    bus.rdy_acc = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    chk("bias_no_done", 32'(bus.done), 0);
    chk("bias_w_hold", 32'(bus.mac_weight), 32'(b));
    acc = acc + h2r(bus.mac_weight);
    if (acc < 0.0) acc = 0.0;
    bus.mac_result = r2h(acc);
    bus.conv_valid = 1'b1;
    @(posedge clk); #1;
    chk("done_pulse", 32'(bus.done), 1);
    chk("done_busy", 32'(bus.busy), 0);
    chk("done_result", 32'(bus.result), 32'(exp_res));
    res_seen = bus.result;
    bus.mac_result = 16'($urandom);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("result_hold", 32'(bus.result), 32'(exp_res));

    nd = d_addr_q.size();
    nw = w_addr_q.size();
    chk("dbuf_reads", 32'(nd), 32'(n));
    chk("wbuf_reads", 32'(nw), 32'(n));
    for (int i = 0; i < n && i < nd; i++) chk("dbuf_addr", 32'(d_addr_q[i]), 32'((db + i) % DEPTH));
    for (int i = 0; i < n && i < nw; i++) chk("wbuf_addr", 32'(w_addr_q[i]), 32'((wb + i) % DEPTH));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] res;
    int dones;
    rst = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.data_base = '0; bus.weight_base = '0; bus.bias = '0;
    bus.rdy_acc = 1'b0; bus.conv_valid = 1'b0; bus.mac_result = '0;
    bus.dbuf_q = '0; bus.wbuf_q = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dmem[i] = vals[$urandom_range(0, 7)];
      wmem[i] = vals[$urandom_range(0, 7)];
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("init");
    rst = 1'b0;
    @(posedge clk); #1;

    dmem[5] = 16'h3C00; wmem[9] = 16'h4000;
    run_job(1, 5, 9, 16'h3C00, res);
    chk("t1_result", 32'(res), 32'h4200);

    for (int i = 0; i < 4; i++) begin dmem[100 + i] = 16'h3C00; wmem[200 + i] = 16'h3800; end
    run_job(4, 100, 200, 16'h0000, res);
    chk("t2_result", 32'(res), 32'h4000);

    run_job(4, DEPTH - 2, DEPTH - 3, 16'h3800, res);

    for (int i = 0; i < 2; i++) begin dmem[300 + i] = 16'h3C00; wmem[400 + i] = 16'hC000; end
    run_job(2, 300, 400, 16'h0000, res);
    chk("t4_clamp", 32'(res), 32'h0000);

    bus.start = 1'b1; bus.len = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("len0_err", 32'(bus.err), 1);
    chk("len0_busy", 32'(bus.busy), 0);
    @(posedge clk); #1;
    chk("len0_err_clear", 32'(bus.err), 0);
    chk("len0_busy_after", 32'(bus.busy), 0);

    bus.start = 1'b1; bus.len = 11'd8; bus.data_base = 10'd500; bus.weight_base = 10'd600;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.conv_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    bus.rdy_acc = 1'b1;
    @(posedge clk); #1;
    bus.rdy_acc = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("midrst_no_done", 32'(dones), 0);
    run_job(2, 700, 800, 16'h3C00, res);

    for (int j = 0; j < 8; j++) begin
      int n;
      int db;
      int wb;
      n  = $urandom_range(1, 12);
      db = (j % 2 == 1) ? DEPTH - $urandom_range(1, 6) : $urandom_range(0, DEPTH - 1);
      wb = $urandom_range(0, DEPTH - 1);
      run_job(n, db, wb, vals[$urandom_range(0, 7)], res);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
